// File: rtl/out_display.sv
// Output stage: latches the CPU bus on load, converts it to decimal with a shift-add-3 engine
// and scans the result onto a 4-digit multiplexed 7-segment display (seg/an registered, 1-cycle latency).
module out_display #(
    parameter int SCAN_DIV = 1000,
    parameter bit SIGNED   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] bus,
    output logic [7:0] value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int PW = $clog2(SCAN_DIV);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_CONV = 1'b1;

    logic          state_q, state_d;
    logic [19:0]   shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          busy_q, busy_d;
    logic [7:0]    value_q, value_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          sign_q, sign_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          bus_neg;
    logic [7:0]    mag;
    logic [19:0]   adj;
    logic [19:0]   shl;
    logic          scan_wrap;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'h3F;
            4'd1:    seg_enc = 7'h06;
            4'd2:    seg_enc = 7'h5B;
            4'd3:    seg_enc = 7'h4F;
            4'd4:    seg_enc = 7'h66;
            4'd5:    seg_enc = 7'h6D;
            4'd6:    seg_enc = 7'h7D;
            4'd7:    seg_enc = 7'h07;
            4'd8:    seg_enc = 7'h7F;
            4'd9:    seg_enc = 7'h6F;
            default: seg_enc = 7'h00;
        endcase
    endfunction

    // 8'h80 negates to itself, which reads correctly as magnitude 128.
    assign bus_neg = SIGNED && bus[7];
    assign mag     = bus_neg ? (~bus + 8'd1) : bus;

    // One double-dabble step: correct each BCD nibble, then shift the whole word left.
    always_comb begin
        adj = shift_q;
        for (int i = 0; i < 3; i++) begin
            if (adj[8 + 4*i +: 4] >= 4'd5) begin
                adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
            end
        end
        shl = adj << 1;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        value_d = value_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        sign_d  = sign_q;
        if (load) begin
            value_d = bus;
            state_d = ST_CONV;
            shift_d = {12'b0, mag};
            cnt_d   = 3'd0;
            neg_d   = bus_neg;
            busy_d  = 1'b1;
        end else if (state_q == ST_CONV) begin
            shift_d = shl;
            cnt_d   = cnt_q + 3'd1;
            // Digits are only published after the final shift so the display never shows partials.
            if (cnt_q == 3'd7) begin
                hund_d  = shl[19:16];
                tens_d  = shl[15:12];
                ones_d  = shl[11:8];
                sign_d  = neg_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    assign scan_wrap = (presc_q == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_d = scan_wrap ? '0 : presc_q + PW'(1);
        idx_d   = scan_wrap ? idx_q + 2'd1 : idx_q;
        an_d    = 4'b0001 << idx_q;
        seg_d   = 7'h00;
        case (idx_q)
            2'd0:    seg_d = seg_enc(ones_q);
            2'd1:    seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? 7'h00 : seg_enc(tens_q);
            2'd2:    seg_d = (hund_q == 4'd0) ? 7'h00 : seg_enc(hund_q);
            default: seg_d = sign_q ? 7'h40 : 7'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            value_q <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            sign_q  <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= 4'b0001;
            seg_q   <= 7'h3F;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            value_q <= value_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            sign_q  <= sign_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign value = value_q;
    assign busy  = busy_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: an unsigned and a signed instance share the same stimulus.
module tb_out_display;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] bus;

    logic [7:0] value_u, value_s;
    logic       busy_u, busy_s;
    logic [6:0] seg_u, seg_s;
    logic [3:0] an_u, an_s;

    int vecs = 0;
    int errs = 0;

    out_display #(.SCAN_DIV(4), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load(load), .bus(bus),
        .value(value_u), .busy(busy_u), .seg(seg_u), .an(an_u)
    );

    out_display #(.SCAN_DIV(4), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .load(load), .bus(bus),
        .value(value_s), .busy(busy_s), .seg(seg_s), .an(an_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        @(posedge clk); #1;
        load = 1'b1;
        bus  = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Counts negedges with busy high, starting just after the load edge; optionally flags a '9' on screen.
    task automatic count_busy(input string tag, input int exp, input bit no_nine);
        int nu = 0;
        int ns = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (no_nine) check({tag, "_no9"}, (seg_u == 7'h6F), 0);
            if (busy_u === 1'b1) nu++;
            if (busy_s === 1'b1) ns++;
            if (busy_u !== 1'b1 && busy_s !== 1'b1) break;
        end
        check({tag, "_busy_u"}, nu, exp);
        check({tag, "_busy_s"}, ns, exp);
    endtask

    task automatic expect_digits(input string tag,
                                 input logic [6:0] u3, input logic [6:0] u2,
                                 input logic [6:0] u1, input logic [6:0] u0,
                                 input logic [6:0] s3, input logic [6:0] s2,
                                 input logic [6:0] s1, input logic [6:0] s0);
        logic [6:0] cu [4];
        logic [6:0] cs [4];
        logic [6:0] eu [4];
        logic [6:0] es [4];
        eu[0] = u0; eu[1] = u1; eu[2] = u2; eu[3] = u3;
        es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
        for (int p = 0; p < 4; p++) begin
            cu[p] = 'x;
            cs[p] = 'x;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                if (an_u == 4'(1 << p)) cu[p] = seg_u;
                if (an_s == 4'(1 << p)) cs[p] = seg_s;
            end
        end
        for (int p = 0; p < 4; p++) begin
            check($sformatf("%s_u_d%0d", tag, p), cu[p], eu[p]);
            check($sformatf("%s_s_d%0d", tag, p), cs[p], es[p]);
        end
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] cur;
        bit         found;

        // Reset takes effect immediately, before any clock edge.
        rst  = 1'b1;
        load = 1'b0;
        bus  = 8'h00;
        #1 rst = 1'b0;
        #1;
        check("rst_value", value_u, 8'd0);
        check("rst_busy", busy_u, 1'b0);
        check("rst_an", an_u, 4'b0001);
        check("rst_seg", seg_u, 7'h3F);
        check("rst_seg_s", seg_s, 7'h3F);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_value", value_u, 8'd0);
            check("idle_busy", busy_u, 1'b0);
            check("idle_1hot", $countones(an_u), 1);
        end

        // Scan stepping with SCAN_DIV=4.
        prev  = an_u;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (an_u !== prev) found = 1'b1;
            else prev = an_u;
        end
        check("scan_sync", found, 1'b1);
        cur = an_u;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i % 4 == 0) cur = {cur[2:0], cur[3]};
            check("scan_an", an_u, cur);
            check("scan_1hot", $countones(an_u), 1);
        end

        // 237: unsigned 237, signed -19.
        @(posedge clk); #1;
        load = 1'b1;
        bus  = 8'd237;
        @(posedge clk); #1;
        load = 1'b0;
        check("ld237_value_imm", value_u, 8'd237);
        count_busy("ld237", 8, 1'b0);
        check("ld237_value", value_u, 8'd237);
        expect_digits("d237", 7'h00, 7'h5B, 7'h4F, 7'h07, 7'h40, 7'h00, 7'h06, 7'h6F);

        // F6: unsigned 246, signed -10.
        do_load(8'hF6);
        count_busy("ldF6", 8, 1'b0);
        expect_digits("dF6", 7'h00, 7'h5B, 7'h66, 7'h7D, 7'h40, 7'h00, 7'h06, 7'h3F);

        // 80: 128 in both views, signed shows the minus sign.
        do_load(8'h80);
        count_busy("ld80", 8, 1'b0);
        check("ld80_value_s", value_s, 8'h80);
        expect_digits("d80", 7'h00, 7'h06, 7'h5B, 7'h7F, 7'h40, 7'h06, 7'h5B, 7'h7F);

        // Reload during conversion: 99 then 5 three cycles later.
        @(posedge clk); #1;
        load = 1'b1;
        bus  = 8'd99;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        check("rl_busy1", busy_u, 1'b1);
        check("rl_no9a", (seg_u == 7'h6F), 0);
        @(posedge clk);
        @(negedge clk);
        check("rl_busy2", busy_u, 1'b1);
        check("rl_no9b", (seg_u == 7'h6F), 0);
        @(posedge clk); #1;
        load = 1'b1;
        bus  = 8'd5;
        @(posedge clk); #1;
        load = 1'b0;
        check("rl_value", value_u, 8'd5);
        count_busy("rl", 8, 1'b1);
        expect_digits("d5", 7'h00, 7'h00, 7'h00, 7'h6D, 7'h00, 7'h00, 7'h00, 7'h6D);

        // Reset in the middle of a conversion, then load must be ignored while held.
        do_load(8'd200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_busy_pre", busy_u, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mid_busy", busy_u, 1'b0);
        check("mid_value", value_u, 8'd0);
        check("mid_an", an_u, 4'b0001);
        check("mid_seg", seg_u, 7'h3F);
        check("mid_busy_s", busy_s, 1'b0);
        load = 1'b1;
        bus  = 8'd55;
        @(posedge clk); #1;
        check("rstld_value", value_u, 8'd0);
        check("rstld_busy", busy_u, 1'b0);
        load = 1'b0;
        rst  = 1'b1;
        expect_digits("dpost", 7'h00, 7'h00, 7'h00, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h3F);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
